// File: rtl/seg7_bus_reader_if.sv
// Multiplexed 7-segment bus plus decoded-frame status.
// The master drives the segment/digit lines; the slave (reader) returns the frame.
interface seg7_bus_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic                    valid_out;
  logic                    frame_err;
  logic [NUM_DIGITS-1:0]   seen_mask;

  modport master (
    output seg_in, dig_sel,
    input  value_out, valid_out, frame_err, seen_mask
  );

  modport slave (
    input  seg_in, dig_sel,
    output value_out, valid_out, frame_err, seen_mask
  );
endinterface

// File: rtl/seg7_bus_reader.sv
// Watches a multiplexed 7-segment bus, decodes each settled digit back
// to a hex nibble and publishes a full frame with a one-cycle valid pulse.
module seg7_bus_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input logic              clk,
  input logic              rst,
  seg7_bus_reader_if.slave bus
);
  localparam int SW = 7 + NUM_DIGITS;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]         in_w;
  logic [SW-1:0]         sample_q;
  logic [7:0]            stab_cnt;
  logic                  captured;
  logic [VW-1:0]         shadow;
  logic                  err_acc;
  logic [NUM_DIGITS-1:0] seen_q;
  logic [VW-1:0]         value_q;
  logic                  valid_q;
  logic                  ferr_q;

  logic [NUM_DIGITS-1:0] samp_dig;
  logic [6:0]            samp_seg;
  logic                  one_hot;
  logic                  do_cap;
  logic                  done;
  logic                  legal;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] seen_base;
  logic                  acc_base;

  assign in_w = ACTIVE_LOW ? ~{bus.dig_sel, bus.seg_in}
                           :  {bus.dig_sel, bus.seg_in};

  assign samp_dig = sample_q[SW-1:7];
  assign samp_seg = sample_q[6:0];
  assign one_hot  = (samp_dig != '0) &&
                    ((samp_dig & (samp_dig - 1'b1)) == '0);
  assign do_cap   = (stab_cnt == STAB_LAST) && !captured && one_hot;
  assign done     = &seen_q;

  assign seen_base = done ? '0 : seen_q;
  assign acc_base  = done ? 1'b0 : err_acc;

  // Segment pattern to nibble; anything off the table is illegal
  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (samp_seg)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // Sampling, dwell tracking, capture and frame publication
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      stab_cnt <= '0;
      captured <= 1'b0;
      shadow   <= '0;
      err_acc  <= 1'b0;
      seen_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sample_q <= in_w;
      valid_q  <= done;
      if (done) begin
        value_q <= shadow;
        ferr_q  <= err_acc;
      end
      seen_q  <= seen_base | (do_cap ? samp_dig : '0);
      err_acc <= acc_base | (do_cap && !legal);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (do_cap && legal && samp_dig[i])
          shadow[4*i +: 4] <= nib;
      end
      if (do_cap)
        captured <= 1'b1;
      // A new sample starts a fresh dwell; this wins over a capture
      if (in_w == sample_q) begin
        if (stab_cnt != 8'hFF)
          stab_cnt <= stab_cnt + 8'd1;
      end else begin
        stab_cnt <= '0;
        captured <= 1'b0;
      end
    end
  end

  assign bus.value_out = value_q;
  assign bus.valid_out = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.seen_mask = seen_q;
endmodule

// File: tb/tb_seg7_bus_reader.sv
// Bench for seg7_bus_reader: directed phases plus random dwells, checked
// every cycle against a dwell-level model, on active-high and active-low copies.
module tb_seg7_bus_reader;
  localparam int N = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  seg7_bus_reader_if #(.NUM_DIGITS(N)) bus ();
  seg7_bus_reader_if #(.NUM_DIGITS(N)) bus_l ();

  assign bus_l.seg_in  = ~bus.seg_in;
  assign bus_l.dig_sel = ~bus.dig_sel;

  seg7_bus_reader #(
    .NUM_DIGITS(N), .STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  seg7_bus_reader #(
    .NUM_DIGITS(N), .STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l)
  );

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what has been on the bus, for how many edges, and the frame state
  logic [6:0]   m_cur_seg;
  logic [N-1:0] m_cur_dig;
  int           m_run;
  bit           m_cap;
  logic [N-1:0] m_seen;
  bit           m_acc;
  logic [3:0]   m_slot [N];
  logic [4*N-1:0] m_value;
  bit           m_ferr;
  bit           m_valid;

  always @(posedge clk) begin
    if (rst) begin
      started   = 1'b1;
      m_cur_seg = '0;
      m_cur_dig = '0;
      m_run     = 1;
      m_cap     = 1'b0;
      m_seen    = '0;
      m_acc     = 1'b0;
      for (int i = 0; i < N; i++) m_slot[i] = 4'h0;
      m_value   = '0;
      m_ferr    = 1'b0;
      m_valid   = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_seen == {N{1'b1}}) begin
        for (int i = 0; i < N; i++) m_value[4*i +: 4] = m_slot[i];
        m_ferr  = m_acc;
        m_valid = 1'b1;
        m_seen  = '0;
        m_acc   = 1'b0;
      end
      if (m_run >= S && !m_cap && $countones(m_cur_dig) == 1) begin
        int pos;
        int hit;
        m_cap = 1'b1;
        pos = 0;
        for (int i = 0; i < N; i++) if (m_cur_dig[i]) pos = i;
        m_seen[pos] = 1'b1;
        hit = -1;
        for (int v = 0; v < 16; v++) if (tbl[v] == m_cur_seg) hit = v;
        if (hit >= 0) m_slot[pos] = 4'(hit);
        else m_acc = 1'b1;
      end
      if (bus.seg_in == m_cur_seg && bus.dig_sel == m_cur_dig) begin
        m_run++;
      end else begin
        m_cur_seg = bus.seg_in;
        m_cur_dig = bus.dig_sel;
        m_run = 1;
        m_cap = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of both copies against the model
  always @(negedge clk) begin
    if (started) begin
      if (bus.valid_out === 1'b1) pulses++;
      chk("valid", 32'(bus.valid_out), 32'(m_valid));
      chk("value", 32'(bus.value_out), 32'(m_value));
      chk("ferr", 32'(bus.frame_err), 32'(m_ferr));
      chk("seen", 32'(bus.seen_mask), 32'(m_seen));
      chk("al_valid", 32'(bus_l.valid_out), 32'(m_valid));
      chk("al_value", 32'(bus_l.value_out), 32'(m_value));
      chk("al_ferr", 32'(bus_l.frame_err), 32'(m_ferr));
      chk("al_seen", 32'(bus_l.seen_mask), 32'(m_seen));
    end
  end

  task automatic drive(logic [N-1:0] dig, logic [6:0] seg, int cycles);
    @(posedge clk);
    #1;
    bus.dig_sel = dig;
    bus.seg_in  = seg;
    repeat (cycles - 1) @(posedge clk);
  endtask

  task automatic show(int pos, logic [6:0] seg, int cycles);
    drive(N'(1 << pos), seg, cycles);
  endtask

  task automatic blank(int cycles);
    drive('0, 7'h00, cycles);
  endtask

  task automatic frame(logic [6:0] p0, logic [6:0] p1,
                       logic [6:0] p2, logic [6:0] p3);
    show(0, p0, 6); blank(1);
    show(1, p1, 6); blank(1);
    show(2, p2, 6); blank(1);
    show(3, p3, 6); blank(2);
  endtask

  initial begin
    int p0;
    bus.seg_in  = '0;
    bus.dig_sel = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    blank(10);
    @(negedge clk);
    chk("idle_value", 32'(bus.value_out), 32'h0);
    chk("idle_seen", 32'(bus.seen_mask), 32'h0);
    chk("idle_pulses", 32'(pulses), 32'd0);

    show(2, 7'h7F, 6); blank(1);
    show(3, 7'h7F, 6); blank(1);
    @(negedge clk);
    chk("pre_rst_seen", 32'(bus.seen_mask), 32'hC);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_seen", 32'(bus.seen_mask), 32'h0);

    p0 = pulses;
    frame(7'h4F, 7'h5B, 7'h06, 7'h3F);
    @(negedge clk);
    chk("f0123_pulses", 32'(pulses - p0), 32'd1);
    chk("f0123_value", 32'(bus.value_out), 32'h0123);
    chk("f0123_ferr", 32'(bus.frame_err), 32'h0);
    chk("f0123_al_value", 32'(bus_l.value_out), 32'h0123);

    show(1, 7'h7F, 3); blank(1);
    @(negedge clk);
    chk("glitch_seen", 32'(bus.seen_mask), 32'h0);
    show(1, 7'h7F, 5); blank(1);
    @(negedge clk);
    chk("glitch2_seen", 32'(bus.seen_mask), 32'h2);
    show(0, 7'h3F, 6); blank(1);
    show(2, 7'h06, 6); blank(1);
    show(3, 7'h3F, 6); blank(2);
    @(negedge clk);
    chk("f0180_value", 32'(bus.value_out), 32'h0180);

    frame(7'h3F, 7'h77, 7'h49, 7'h71);
    @(negedge clk);
    chk("bad_value", 32'(bus.value_out), 32'hF1A0);
    chk("bad_ferr", 32'(bus.frame_err), 32'h1);
    frame(7'h4F, 7'h5B, 7'h06, 7'h3F);
    @(negedge clk);
    chk("clean_ferr", 32'(bus.frame_err), 32'h0);

    drive(4'b0011, 7'h3F, 10); blank(1);
    @(negedge clk);
    chk("multi_seen", 32'(bus.seen_mask), 32'h0);

    show(0, 7'h66, 20); blank(1);
    @(negedge clk);
    chk("long_seen", 32'(bus.seen_mask), 32'h1);

    for (int n = 0; n < 150; n++) begin
      int r;
      logic [N-1:0] d;
      logic [6:0] sg;
      r = $urandom_range(0, 9);
      if (r == 0) d = '0;
      else if (r == 1) d = N'($urandom_range(3, 15));
      else d = N'(1 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 4) == 0) sg = 7'($urandom);
      else sg = tbl[$urandom_range(0, 15)];
      drive(d, sg, $urandom_range(1, 8));
      r = $urandom_range(0, 2);
      if (r != 0) blank(r);
    end
    blank(4);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
